// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and line/parity constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first shift register with data bit counter
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  count,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  ser_bit,
  output logic                  ser_done
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  logic [DATA_WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  assign ser_bit = sr[0];
  assign ser_done = cnt == CW'(DATA_WIDTH - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= p_data;
      cnt <= '0;
    end else begin
      if (shift) sr <= sr >> 1;
      if (count) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: one-bit-per-clock UART frame serializer with optional parity
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);
  state_t state;
  logic par_en_q, parity, ser_bit, ser_done, accept, data_step;
  assign accept = data_valid && (state == IDLE || state == STOP);
  assign data_step = state == DATA && !ser_done;
  // the start edge pre-shifts so ser_bit always holds the next bit to drive
  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .shift(state == START || data_step),
    .count(data_step),
    .p_data(p_data),
    .ser_bit(ser_bit),
    .ser_done(ser_done)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      tx_out <= LINE_IDLE;
      busy <= 1'b0;
      par_en_q <= 1'b0;
      parity <= 1'b0;
    end else
      case (state)
        IDLE, STOP:
          if (accept) begin
            state <= START;
            tx_out <= START_BIT;
            busy <= 1'b1;
            par_en_q <= par_en;
            parity <= (^p_data) ^ (par_typ == PAR_ODD);
          end else begin
            state <= IDLE;
            tx_out <= LINE_IDLE;
            busy <= 1'b0;
          end
        START: begin
          state <= DATA;
          tx_out <= ser_bit;
        end
        DATA:
          if (ser_done) begin
            state <= par_en_q ? PARITY : STOP;
            tx_out <= par_en_q ? parity : STOP_BIT;
          end else
            tx_out <= ser_bit;
        PARITY: begin
          state <= STOP;
          tx_out <= STOP_BIT;
        end
        default: begin
          state <= IDLE;
          tx_out <= LINE_IDLE;
          busy <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench, expected frames queued by stimulus and checked by a line monitor
module tb_uart_tx;
  logic clk = 0, rst = 0, data_valid = 0, par_en = 0, par_typ = 0;
  logic [7:0] p_data = 0;
  logic tx_out, busy;
  typedef struct {logic [15:0] bits; int len;} frame_t;
  frame_t exp_q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_out), .busy(busy)
  );
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // bits are written in transmission order, first bit leftmost
  task automatic push(input logic [15:0] bits, input int len);
    exp_q.push_back(frame_t'{bits: bits, len: len});
  endtask
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [15:0] bits, input int len);
    @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1;
    push(bits, len);
    @(negedge clk);
    data_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    frame_t cur;
    int idx;
    bit act;
    act = 0;
    idx = 0;
    forever begin
      @(negedge clk);
      if (!rst) act = 0;
      else begin
        if (!act && busy) begin
          check("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            act = 1;
            idx = 0;
          end
        end
        if (act) begin
          check("busy_in_frame", busy, 1);
          check("frame_bit", tx_out, cur.bits[cur.len-1-idx]);
          idx++;
          if (idx == cur.len) act = 0;
        end else
          check("idle_line", {busy, tx_out}, 2'b01);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    rst = 1;
    repeat (20) @(negedge clk);
    #2 rst = 0;
    #1 check("idle_rst_tx", tx_out, 1);
    check("idle_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    send(8'hA5, 0, 0, 16'b0101001011, 10);
    wait_idle();
    send(8'hA5, 1, 0, 16'b01010010101, 11);
    wait_idle();
    send(8'hA5, 1, 1, 16'b01010010111, 11);
    wait_idle();
    @(negedge clk);
    p_data = 8'h3C; par_en = 0; par_typ = 0; data_valid = 1;
    push(16'b0001111001, 10);
    push(16'b0110000111, 10);
    @(negedge clk);
    p_data = 8'hC3;
    repeat (10) @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_start", tx_out, 0);
    data_valid = 0;
    wait_idle();
    send(8'h0F, 0, 0, 16'b0111100001, 10);
    repeat (2) @(negedge clk);
    p_data = 8'hFF; par_en = 1; data_valid = 1;
    @(negedge clk);
    data_valid = 0;
    wait_idle();
    repeat (12) @(negedge clk);
    send(8'hA5, 0, 0, 16'b0101001011, 10);
    repeat (4) @(negedge clk);
    #2 rst = 0;
    #1 check("midframe_rst_tx", tx_out, 1);
    check("midframe_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    send(8'h55, 0, 0, 16'b0101010101, 10);
    wait_idle();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
